// File: rtl/tap_tempo.sv
// Tap-tempo detector: measures tap intervals in dclk22 ticks, averages the last
// four and converts the mean interval to a clamped beats-per-minute value.
module tap_tempo #(
  parameter int TICKS_PER_MIN = 1430,
  parameter int BPM_INIT      = 88,
  parameter int BPM_MIN       = 40,
  parameter int BPM_MAX       = 220,
  parameter int MIN_INT       = 4,
  parameter int TIMEOUT       = 48
) (
  input  logic        dclk22,
  input  logic        rst,
  input  logic        en,
  input  logic        tap,
  output logic [31:0] bpm_out,
  output logic        bpm_valid,
  output logic        tapping,
  output logic [2:0]  ntap
);

  localparam logic [15:0] TPM    = 16'(TICKS_PER_MIN);
  localparam logic [15:0] LO     = 16'(BPM_MIN);
  localparam logic [15:0] HI     = 16'(BPM_MAX);
  localparam logic [15:0] MIN_C  = 16'(MIN_INT);
  localparam logic [15:0] TO_C   = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARMED, COMPUTE} state_t;

  state_t            state, state_n;
  logic [15:0]       cnt, cnt_n;
  logic [3:0][15:0]  hist, hist_n;
  logic [2:0]        ntap_n;
  logic [31:0]       bpm_n;
  logic              vld_n;
  logic              tap_d;
  logic              tap_edge;
  logic [15:0]       sum_p0, num_p0, raw_p0;

  function automatic logic [15:0] clamp_bpm(input logic [15:0] v);
    if (v < LO) return LO;
    if (v > HI) return HI;
    return v;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v >= TO_C) return TO_C;
    return v + 16'd1;
  endfunction

  assign tap_edge = tap & ~tap_d;

  // Stage p0: average of the newest ntap intervals, expressed as bpm
  always_comb begin
    sum_p0 = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < ntap) sum_p0 = sum_p0 + hist[i];
    end
    num_p0 = TPM * 16'(ntap);
    raw_p0 = (sum_p0 == 16'd0) ? 16'hFFFF : num_p0 / sum_p0;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hist_n  = hist;
    ntap_n  = ntap;
    bpm_n   = bpm_out;
    vld_n   = 1'b0;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      hist_n  = '0;
      ntap_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (tap_edge) begin
            state_n = ARMED;
            cnt_n   = 16'd1;
            ntap_n  = '0;
            hist_n  = '0;
          end
        end
        ARMED: begin
          if (tap_edge && cnt >= MIN_C && cnt < TO_C) begin
            hist_n  = {hist[2:0], cnt};
            ntap_n  = (ntap >= 3'd4) ? 3'd4 : ntap + 3'd1;
            cnt_n   = 16'd1;
            state_n = COMPUTE;
          end else if (cnt >= TO_C) begin
            hist_n = '0;
            ntap_n = '0;
            if (tap_edge) begin
              cnt_n = 16'd1;
            end else begin
              cnt_n   = '0;
              state_n = IDLE;
            end
          end else begin
            cnt_n = sat_inc(cnt);
          end
        end
        COMPUTE: begin
          // Taps here are bounce by construction (interval of 1), so only count.
          bpm_n   = {16'd0, clamp_bpm(raw_p0)};
          vld_n   = 1'b1;
          cnt_n   = sat_inc(cnt);
          state_n = ARMED;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Stage p1: registered state, history and outputs
  always_ff @(posedge dclk22) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hist      <= '0;
      ntap      <= '0;
      bpm_out   <= 32'(BPM_INIT);
      bpm_valid <= 1'b0;
      tapping   <= 1'b0;
      tap_d     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hist      <= hist_n;
      ntap      <= ntap_n;
      bpm_out   <= bpm_n;
      bpm_valid <= vld_n;
      tapping   <= (state_n != IDLE);
      tap_d     <= tap;
    end
  end

endmodule
